// File: rtl/rs232_to_axis_pkg.sv
// ---------------------------------------------------------------------------
// rs232_to_axis_pkg
// Shared definitions for the RS232 receive path:
//   - rx_state_t      : receiver FSM state encoding (also exported for debug)
//   - SYNC_STAGES     : depth of the rxd_pin synchronizer
//   - baud_cnt_width  : width of a down-counter that must hold baud_count-1
// ---------------------------------------------------------------------------
package rs232_to_axis_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int SYNC_STAGES = 2;

    // The counter only ever holds values in 0 .. baud_count-1.
    function automatic int baud_cnt_width(input int baud_count);
        return (baud_count <= 2) ? 1 : $clog2(baud_count);
    endfunction

endpackage

// File: rtl/rs232_to_axis_if.sv
// ---------------------------------------------------------------------------
// rs232_to_axis_if
// Byte-wide AXI-stream style output of the RS232 receiver.
//   odata  : byte at the FIFO head
//   ovalid : a byte is available
//   oready : consumer accepts
// Handshake: a transfer happens on a rising clock edge where ovalid && oready
// are both high; while ovalid is high and oready is low, odata holds steady
// and ovalid stays high.
//   master modport : the receiver (drives odata/ovalid)
//   slave  modport : the consumer (drives oready)
// ---------------------------------------------------------------------------
interface rs232_to_axis_if;
    logic [7:0] odata;
    logic       ovalid;
    logic       oready;

    modport master (output odata, output ovalid, input oready);
    modport slave  (input odata, input ovalid, output oready);
endinterface

// File: rtl/rs232_to_axis_rx_fifo.sv
// ---------------------------------------------------------------------------
// rs232_to_axis_rx_fifo
// Small byte FIFO built from a register array.
// Ports:
//   clock, resetn : rising-edge clock, synchronous active-low reset
//   push, wdata   : write request and data; ignored when full unless a pop
//                   happens in the same cycle
//   pop           : read request; ignored when empty
//   rdata         : head entry, combinational from the array
//   count         : number of stored entries (0 .. DEPTH)
//   empty, full   : status flags derived from count
// ---------------------------------------------------------------------------
module rs232_to_axis_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);

    // A pop frees the head slot in the same edge, so a push while full is
    // still accepted when it coincides with a pop.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rs232_to_axis.sv
// ---------------------------------------------------------------------------
// rs232_to_axis
// RS232 8N1 receiver feeding a byte stream, with RTS flow control.
// Parameters:
//   CLOCK_FREQ : clock frequency in Hz
//   BAUD_RATE  : line rate in baud (CLOCK_FREQ/BAUD_RATE must be >= 8)
//   FIFO_DEPTH : output FIFO entries, power of two, >= 4
// Ports:
//   clock, resetn  : rising-edge clock, synchronous active-low reset
//   axis           : master side of the byte stream (odata/ovalid/oready)
//   rxd_pin        : asynchronous serial input, idles high
//   rtsn_pin       : 1 = sender must stop (wire to the sender's CTSn)
//   framing_error  : one-clock pulse when a stop bit samples low
//   overrun        : one-clock pulse when a byte is dropped on a full FIFO
//   dbg_state      : current receiver FSM state
// ---------------------------------------------------------------------------
module rs232_to_axis
    import rs232_to_axis_pkg::*;
#(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    rs232_to_axis_if.master        axis,
    input  logic                   rxd_pin,
    output logic                   rtsn_pin,
    output logic                   framing_error,
    output logic                   overrun,
    output rx_state_t              dbg_state
);
    localparam int BAUD_COUNT = $rtoi(CLOCK_FREQ / BAUD_RATE);
    localparam int CW         = baud_cnt_width(BAUD_COUNT);
    localparam int AW         = $clog2(FIFO_DEPTH);

    // The start-bit state is entered one clock after rxd_s falls, so the
    // half-bit load is shortened by one extra clock to put the START sample
    // exactly BAUD_COUNT/2 clocks after the falling edge of rxd_s.
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_COUNT / 2 - 2);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   CNT_STEP  = (AW + 1)'(1);
    localparam logic [AW:0]   RTS_LEVEL = (AW + 1)'(FIFO_DEPTH - 2);

    // ----------------------------------------------------------------------
    // Input synchronizer
    // ----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   rxd_s;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], rxd_pin};
        end
    end

    assign rxd_s = sync_ff[SYNC_STAGES-1];

    // ----------------------------------------------------------------------
    // Receiver FSM, baud counter and shift register
    // ----------------------------------------------------------------------
    rx_state_t     state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sample_tick;

    assign sample_tick = (baud_cnt == '0);
    assign dbg_state   = state;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state    <= START;
                        baud_cnt <= HALF_LOAD;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        baud_cnt <= FULL_LOAD;
                        if (rxd_s) begin
                            // Line went back high before mid start bit.
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        baud_cnt <= FULL_LOAD;
                        shreg    <= {rxd_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        baud_cnt <= FULL_LOAD;
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    // Break or stuck-low line: resync only once it idles.
                    if (rxd_s) begin
                        state    <= IDLE;
                        baud_cnt <= FULL_LOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------------------
    // Output FIFO and flow control
    // ----------------------------------------------------------------------
    logic          push;
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_ok;
    logic          pop_ok;
    logic [AW:0]   count_next;

    // The shift register already holds all 8 data bits during the STOP
    // sample, so the byte is pushed in that same cycle.
    assign push = (state == STOP) && sample_tick && rxd_s;
    assign pop  = !fifo_empty && axis.oready;

    assign pop_ok  = pop;
    assign push_ok = push && (!fifo_full || pop_ok);

    always_comb begin
        count_next = fifo_count;
        if (push_ok && !pop_ok) begin
            count_next = fifo_count + CNT_STEP;
        end else if (!push_ok && pop_ok) begin
            count_next = fifo_count - CNT_STEP;
        end
    end

    rs232_to_axis_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .wdata  (shreg),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign axis.ovalid = !fifo_empty;
    assign axis.odata  = fifo_rdata;

    // RTS is raised while two slots are still free so that a byte the sender
    // already started after seeing RTS rise still fits.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rtsn_pin <= 1'b1;
            overrun  <= 1'b0;
        end else begin
            rtsn_pin <= (count_next >= RTS_LEVEL);
            overrun  <= push && fifo_full && !pop_ok;
        end
    end

endmodule
